// File: rtl/collram_ext.sv
// Collision RAM: one flag bit per entry, set by hardware collision strobes, cleared by CPU or a full sweep.
// Also keeps a summary flag, the first-hit address and a saturating hit counter, all readable through one registered port.
module collram_ext #(
  parameter int AW    = 10,
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          RESET,
  input  logic [AW-1:0] cpu_ad,
  input  logic [1:0]    cpu_sel,
  input  logic          cpu_wr_coll,
  input  logic          cpu_wr_collclr,
  output logic [7:0]    cpu_rd_coll,
  input  logic [AW-1:0] coll_ad,
  input  logic          coll,
  output logic          busy
);

  // state | meaning
  // IDLE  | no sweep running; waits for a start strobe or reset release
  // SWEEP | clears one entry per cycle, sweep_ad walking 0 .. 2**AW-1
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;

  localparam int DEPTH = 1 << AW;

  logic [0:0]       state;
  logic [AW-1:0]    sweep_ad;
  logic             rst_q;
  logic [DEPTH-1:0] entry;
  logic             coll_sm;
  logic             first_v;
  logic [AW-1:0]    first_ad;
  logic [CNT_W-1:0] count;
  logic [9:0]       first_ext;
  logic [7:0]       count_ext;
  logic             sweep_start;
  logic             cpu_clr;

  assign sweep_start = cpu_wr_coll && (cpu_sel == 2'd3);
  assign cpu_clr     = cpu_wr_coll && (cpu_sel == 2'd0);
  assign busy        = (state == ST_SWEEP);

  // rst_q remembers that reset was just released, which kicks off the power-up sweep
  always_ff @(posedge clk) begin
    if (RESET) begin
      state    <= ST_IDLE;
      sweep_ad <= '0;
      rst_q    <= 1'b1;
    end else begin
      rst_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rst_q || sweep_start) begin
            state    <= ST_SWEEP;
            sweep_ad <= '0;
          end
        end
        default: begin
          if (&sweep_ad) state <= ST_IDLE;
          else sweep_ad <= sweep_ad + AW'(1);
        end
      endcase
    end
  end

  // Later assignments take priority, so any clear beats a set on the same entry
  always_ff @(posedge clk) begin
    if (coll) entry[coll_ad] <= 1'b1;
    if (cpu_clr) entry[cpu_ad] <= 1'b0;
    if (busy && !RESET) entry[sweep_ad] <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      coll_sm  <= 1'b0;
      first_v  <= 1'b0;
      first_ad <= '0;
      count    <= '0;
    end else if (cpu_wr_collclr) begin
      coll_sm  <= 1'b0;
      first_v  <= 1'b0;
      first_ad <= '0;
      count    <= '0;
    end else if (coll) begin
      coll_sm <= 1'b1;
      if (!first_v) begin
        first_v  <= 1'b1;
        first_ad <= coll_ad;
      end
      if (!(&count)) count <= count + CNT_W'(1);
    end
  end

  always_comb begin
    first_ext           = '0;
    first_ext[AW-1:0]   = first_ad;
    count_ext           = '0;
    count_ext[CNT_W-1:0] = count;
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      cpu_rd_coll <= 8'h00;
    end else begin
      case (cpu_sel)
        2'd0:    cpu_rd_coll <= {coll_sm, busy, 5'b11111, entry[cpu_ad]};
        2'd1:    cpu_rd_coll <= first_ext[7:0];
        2'd2:    cpu_rd_coll <= {first_v, 5'b00000, first_ext[9:8]};
        default: cpu_rd_coll <= count_ext;
      endcase
    end
  end

endmodule

// File: tb/tb_collram_ext.sv
// Bench for collram_ext (AW=10, CNT_W=4): array-based reference model checked every cycle,
// plus directed reads with hand-computed values.
module tb_collram_ext;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic [9:0] cpu_ad = '0;
  logic [1:0] cpu_sel = '0;
  logic       cpu_wr_coll = 1'b0;
  logic       cpu_wr_collclr = 1'b0;
  logic [7:0] cpu_rd_coll;
  logic [9:0] coll_ad = '0;
  logic       coll = 1'b0;
  logic       busy;

  int checks = 0;
  int errors = 0;

  collram_ext #(.AW(10), .CNT_W(4)) dut (
    .clk(clk), .RESET(RESET), .cpu_ad(cpu_ad), .cpu_sel(cpu_sel),
    .cpu_wr_coll(cpu_wr_coll), .cpu_wr_collclr(cpu_wr_collclr),
    .cpu_rd_coll(cpu_rd_coll), .coll_ad(coll_ad), .coll(coll), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model
  bit         m_entry [1024];
  bit         m_kn [1024];
  bit         m_sm, m_fv, m_sw, m_prev_rst, m_started;
  logic [9:0] m_fad;
  int         m_cnt, m_sad;
  logic [7:0] exp_rd;
  bit         exp_valid, exp_busy;

  always @(posedge clk) begin
    exp_valid = 1'b1;
    if (RESET) exp_rd = 8'h00;
    else begin
      case (cpu_sel)
        2'd0: begin
          exp_rd = {m_sm, m_sw, 5'b11111, m_entry[cpu_ad]};
          if (!m_kn[cpu_ad]) exp_valid = 1'b0;
        end
        2'd1: exp_rd = m_fad[7:0];
        2'd2: exp_rd = {m_fv, 5'b0, m_fad[9:8]};
        default: exp_rd = 8'(m_cnt);
      endcase
    end
    if (coll) begin m_entry[coll_ad] = 1; m_kn[coll_ad] = 1; end
    if (cpu_wr_coll && cpu_sel == 2'd0) begin m_entry[cpu_ad] = 0; m_kn[cpu_ad] = 1; end
    if (RESET) begin
      m_sm = 0; m_fv = 0; m_fad = '0; m_cnt = 0; m_sw = 0;
    end else begin
      if (m_sw) begin m_entry[m_sad] = 0; m_kn[m_sad] = 1; end
      if (cpu_wr_collclr) begin
        m_sm = 0; m_fv = 0; m_fad = '0; m_cnt = 0;
      end else if (coll) begin
        m_sm = 1;
        if (!m_fv) begin m_fv = 1; m_fad = coll_ad; end
        if (m_cnt < 15) m_cnt++;
      end
      if (m_sw) begin
        if (m_sad == 1023) m_sw = 0;
        else m_sad++;
      end else if (m_prev_rst || (cpu_wr_coll && cpu_sel == 2'd3)) begin
        m_sw = 1; m_sad = 0;
      end
    end
    m_prev_rst = RESET;
    exp_busy  = m_sw;
    m_started = 1;
  end

  always @(negedge clk) begin
    if (m_started) begin
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL model_busy t=%0t got %b want %b", $time, busy, exp_busy);
      end
      if (exp_valid) begin
        checks++;
        if (cpu_rd_coll !== exp_rd) begin
          errors++;
          $display("FAIL model_rd t=%0t got %h want %h", $time, cpu_rd_coll, exp_rd);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, want);
    end
  endtask

  // Called at a negedge; returns the registered read one cycle later
  task automatic rd(input logic [1:0] sel, input logic [9:0] ad, output logic [7:0] v);
    cpu_sel = sel; cpu_ad = ad;
    @(negedge clk);
    v = cpu_rd_coll;
  endtask

  task automatic pulse_coll(input logic [9:0] ad);
    coll = 1'b1; coll_ad = ad;
    @(negedge clk);
    coll = 1'b0;
  endtask

  task automatic pulse_clr();
    cpu_wr_collclr = 1'b1;
    @(negedge clk);
    cpu_wr_collclr = 1'b0;
  endtask

  // Counts busy-high cycles until busy drops, bounded
  task automatic count_busy(output int n);
    bit done = 0;
    n = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (busy) n++;
      else if (n > 0) done = 1;
    end
  endtask

  logic [7:0] v;
  int n;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_rd", 32'(cpu_rd_coll), 32'h00);
    check("reset_busy", 32'(busy), 32'h0);

    RESET = 1'b0;
    count_busy(n);
    check("powerup_sweep_len", n, 1024);
    begin
      int bad = 0;
      for (int a = 0; a < 1024; a++) begin
        rd(2'd0, 10'(a), v);
        if (v[0] !== 1'b0) bad++;
      end
      check("entries_zero_after_sweep", bad, 0);
    end

    pulse_coll(10'h155);
    pulse_coll(10'h2AA);
    rd(2'd0, 10'h155, v); check("sel0_155", 32'(v), 32'hBF);
    rd(2'd1, 10'h000, v); check("sel1_first_lo", 32'(v), 32'h55);
    rd(2'd2, 10'h000, v); check("sel2_first_hi", 32'(v), 32'h81);
    rd(2'd3, 10'h000, v); check("sel3_count2", 32'(v), 32'h02);
    rd(2'd0, 10'h2AA, v); check("sel0_2AA", 32'(v), 32'hBF);

    pulse_clr();
    coll = 1'b1; coll_ad = 10'h010; cpu_wr_coll = 1'b1; cpu_sel = 2'd0; cpu_ad = 10'h010;
    @(negedge clk);
    coll = 1'b0; cpu_wr_coll = 1'b0;
    rd(2'd0, 10'h010, v); check("same_cycle_clear_wins", 32'(v), 32'hBE);
    coll = 1'b1; coll_ad = 10'h010; cpu_wr_coll = 1'b1; cpu_sel = 2'd0; cpu_ad = 10'h011;
    @(negedge clk);
    coll = 1'b0; cpu_wr_coll = 1'b0;
    rd(2'd0, 10'h010, v); check("set_kept_other_clear", 32'(v), 32'hBF);
    rd(2'd0, 10'h011, v); check("other_entry_cleared", 32'(v), 32'hBE);

    pulse_clr();
    for (int i = 0; i < 20; i++) pulse_coll(10'h1A0 + 10'(i));
    rd(2'd3, 10'h000, v); check("count_saturates", 32'(v), 32'h0F);
    rd(2'd1, 10'h000, v); check("first_held_lo", 32'(v), 32'hA0);
    cpu_wr_coll = 1'b1; cpu_sel = 2'd1; @(negedge clk);
    cpu_sel = 2'd2; @(negedge clk);
    cpu_wr_coll = 1'b0;
    rd(2'd2, 10'h000, v); check("sel12_write_noop", 32'(v), 32'h81);
    cpu_wr_collclr = 1'b1; coll = 1'b1; coll_ad = 10'h3C0;
    @(negedge clk);
    cpu_wr_collclr = 1'b0; coll = 1'b0;
    rd(2'd3, 10'h000, v); check("clr_wins_count", 32'(v), 32'h00);
    rd(2'd2, 10'h000, v); check("clr_wins_first_v", 32'(v), 32'h00);
    rd(2'd0, 10'h3C0, v); check("clr_wins_sm_entry_set", 32'(v), 32'h3F);

    pulse_coll(10'h3FF);
    cpu_wr_coll = 1'b1; cpu_sel = 2'd3;
    n = 0;
    begin
      bit done = 0;
      for (int i = 0; i < 2000 && !done; i++) begin
        @(negedge clk);
        coll = 1'b0; cpu_wr_coll = 1'b0;
        if (busy) n++;
        else if (n > 0) done = 1;
        if (i == 256) begin coll = 1'b1; coll_ad = 10'h3FF; end
        if (i == 400) begin cpu_wr_coll = 1'b1; cpu_sel = 2'd3; end
        if (i == 600) begin coll = 1'b1; coll_ad = 10'h050; end
      end
    end
    check("sweep_no_restart_len", n, 1024);
    rd(2'd0, 10'h3FF, v); check("sweep_clears_3FF", 32'(v), 32'hBE);
    rd(2'd0, 10'h050, v); check("set_after_sweep_passed", 32'(v), 32'hBF);

    cpu_wr_coll = 1'b1; cpu_sel = 2'd3;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      coll = 1'b0; cpu_wr_coll = 1'b0;
      if (i == 50) begin coll = 1'b1; coll_ad = 10'h005; end
    end
    coll = 1'b0;
    RESET = 1'b1;
    @(negedge clk);
    check("reset_aborts_sweep", 32'(busy), 32'h0);
    @(negedge clk);
    RESET = 1'b0;
    count_busy(n);
    check("restart_sweep_len", n, 1024);
    rd(2'd0, 10'h005, v); check("restart_from_zero", 32'(v), 32'h3E);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/collram_ext.md
COLLRAM_EXT -- requirements
Module: collram_ext

Interface
REQ-001 SHALL have parameter AW, default 10, meaning the entry address width (depth = 2**AW one-bit entries, 1 <= AW <= 10).
REQ-002 SHALL have parameter CNT_W, default 8, meaning the hit-counter width (1 <= CNT_W <= 8).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port RESET, input, 1, synchronous active-high reset.
REQ-005 SHALL have port cpu_ad, input, AW, the CPU entry address.
REQ-006 SHALL have port cpu_sel, input, 2, the CPU read/write target: 0 = entry, 1 = first-hit low, 2 = first-hit high, 3 = hit count.
REQ-007 SHALL have port cpu_wr_coll, input, 1, the CPU clear strobe (entry clear when cpu_sel=0, sweep start when cpu_sel=3).
REQ-008 SHALL have port cpu_wr_collclr, input, 1, which clears the summary flag, first-hit capture and hit count.
REQ-009 SHALL have port cpu_rd_coll, output, 8, registered CPU read data.
REQ-010 SHALL have port coll_ad, input, AW, the hardware collision address.
REQ-011 SHALL have port coll, input, 1, the hardware collision strobe (one clk cycle per event).
REQ-012 SHALL have port busy, output, 1, high while a clear sweep runs.

Function
REQ-013 SHALL set entry[coll_ad] on coll=1, unless the same entry is cleared in the same cycle; clear wins.
REQ-014 SHALL clear entry[cpu_ad] on cpu_wr_coll=1 with cpu_sel=0, and still apply a simultaneous coll set to a different address (no dropped set).
REQ-015 SHALL set summary flag coll_sm on coll=1; cpu_wr_collclr in the same cycle wins (coll_sm=0).
REQ-016 SHALL capture coll_ad into first_ad and set first_v on the first coll while first_v=0; later hits leave first_ad unchanged until cpu_wr_collclr.
REQ-017 SHALL increment hit count on each coll, saturating at 2**CNT_W-1; cpu_wr_collclr zeroes it, and wins over a simultaneous coll.
REQ-018 SHALL implement sweep FSM states IDLE and SWEEP; IDLE->SWEEP on cpu_wr_coll with cpu_sel=3, or on the cycle after RESET deasserts.
REQ-019 SHALL, in SWEEP, clear entry[sweep_ad] once per cycle, with sweep_ad going 0 to 2**AW-1, then enter IDLE; busy=1 exactly while in SWEEP (2**AW cycles).
REQ-020 SHALL, in SWEEP, still apply coll sets to addresses other than sweep_ad; the sweep clear wins at sweep_ad; CPU entry clears remain honoured.
REQ-021 SHALL ignore a sweep-start strobe received while already in SWEEP (no restart).
REQ-022 SHALL register cpu_rd_coll one cycle after cpu_ad/cpu_sel are presented (latency 1), reflecting state before that edge's writes.
REQ-023 SHALL format cpu_rd_coll by cpu_sel as: 0 -> {coll_sm, busy, 5'b11111, entry}; 1 -> first_ad[7:0] zero-extended; 2 -> {first_v, 5'b0, first_ad[9:8]} with absent bits 0; 3 -> count zero-extended to 8 bits.
REQ-024 SHALL treat writes with cpu_wr_coll=1 and cpu_sel 1 or 2 as no-ops.

Reset
REQ-025 SHALL, on RESET=1, set coll_sm=0, first_v=0, first_ad=0, count=0, cpu_rd_coll=8'h00, FSM=IDLE, busy=0; entries are not cleared during reset.
REQ-026 SHALL start the automatic sweep the cycle after RESET falls, so that all entries read 0 once busy drops.
REQ-027 SHALL, on RESET asserted mid-sweep, abort the sweep (busy=0 next edge) and restart it from address 0 after RESET falls.

Verification
REQ-028 SHALL be checked with AW=10: release RESET -> busy=1 for exactly 1024 cycles; entry 0..1023 reads bit0=0 afterwards.
REQ-029 SHALL be checked with coll at coll_ad=0x155, then at 0x2AA -> sel0@0x155 reads 8'hBF (coll_sm=1, busy=0, entry=1); sel1 reads 8'h55; sel2 reads 8'h81; sel3 reads 8'h02.
REQ-030 SHALL be checked with the same-cycle case coll_ad=cpu_ad=0x010, coll=1, cpu_wr_coll=1, sel0 -> entry 0x010 reads 0, coll_sm=1; repeating with cpu_ad=0x011 -> entry 0x010=1.
REQ-031 SHALL be checked with CNT_W=4 and 20 coll pulses -> count reads 8'h0F; cpu_wr_collclr coincident with coll -> count 0, coll_sm 0, first_v 0.
REQ-032 SHALL be checked with a sweep started, coll at 0x3FF while sweep_ad=0x100, and a second start strobe mid-sweep -> busy stays high for only 1024 cycles total; 0x3FF ends 0; a coll at 0x050 after sweep_ad has passed 0x050 leaves entry 0x050 = 1.
